router_sync_n: RTL and testbench



---
 rtl/router_sync_n.sv | 127 ++++++++++++
 tb/tb_router_sync_n.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// ----------------------------------------------------------------------------
// router_sync_n
// Router synchroniser. It latches the destination channel from the header
// byte and steers the payload write strobe to that channel's FIFO. It reports
// the full flag of the latched channel and a per-channel valid flag. A channel
// whose data sits unread for TIMEOUT cycles gets a one-cycle soft_reset pulse.
//
// Optional feature: define ROUTER_SYNC_ADDR_ERR_EN to add the registered
// addr_err output. addr_err flags a header whose address is >= NUM_CH.
//
// Ports
//   clk           in   rising-edge clock
//   resetn        in   synchronous active-low reset
//   detect_add    in   header strobe; address valid this cycle
//   address       in   [ADDR_W]  destination channel
//   write_enb_reg in   payload write request
//   read_enb      in   [NUM_CH]  per-channel read strobe
//   empty         in   [NUM_CH]  per-channel FIFO empty
//   full          in   [NUM_CH]  per-channel FIFO full
//   write_enb     out  [NUM_CH]  one-hot FIFO write enable (combinational)
//   fifo_full     out  full flag of the latched channel (combinational)
//   addr_err      out  invalid-address flag, registered (macro only)
//   vld_out       out  [NUM_CH]  ~empty (combinational)
//   soft_reset    out  [NUM_CH]  registered timeout flush pulse
// ----------------------------------------------------------------------------
module router_sync_n #(
   parameter int NUM_CH  = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic [ADDR_W-1:0] address,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] read_enb,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] full,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
`ifdef ROUTER_SYNC_ADDR_ERR_EN
   output logic              addr_err,
`endif
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NUM_CH-1:0] sel;
   logic [NUM_CH-1:0] soft_q, soft_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];

   // Header address register
   always_comb begin
      addr_d = addr_q;
      if (detect_add) addr_d = address;
   end

   always_ff @(posedge clk) begin
      if (!resetn) addr_q <= '0;
      else         addr_q <= addr_d;
   end

   // Decode of the latched channel. An address >= NUM_CH matches no bit,
   // so write_enb and fifo_full are masked to zero.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_sel
      always_comb sel[g] = (32'(addr_q) == g);
   end

   always_comb begin
      write_enb = sel & {NUM_CH{write_enb_reg}};
      fifo_full = |(full & sel);
      vld_out   = ~empty;
   end

   // Per-channel unread timeout. The counter holds the number of
   // consecutive unread valid edges seen. The edge that would make it reach
   // TIMEOUT fires the pulse and restarts the count. Read or empty clears it
   // first.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_tmo
      always_comb begin
         cnt_d[g]  = cnt_q[g];
         soft_d[g] = 1'b0;
         if (read_enb[g] || empty[g]) begin
            cnt_d[g] = '0;
         end else if (cnt_q[g] == CNT_LAST) begin
            cnt_d[g]  = '0;
            soft_d[g] = 1'b1;
         end else begin
            cnt_d[g] = cnt_q[g] + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!resetn) begin
            cnt_q[g]  <= '0;
            soft_q[g] <= 1'b0;
         end else begin
            cnt_q[g]  <= cnt_d[g];
            soft_q[g] <= soft_d[g];
         end
      end
   end

   always_comb soft_reset = soft_q;

`ifdef ROUTER_SYNC_ADDR_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (detect_add) err_d = !(32'(address) < NUM_CH);
   end

   always_ff @(posedge clk) begin
      if (!resetn) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   always_comb addr_err = err_q;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// ----------------------------------------------------------------------------
// tb_router_sync_n
// Directed bench for router_sync_n (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
// Stimulus changes inputs 1ns after each rising edge. It pushes the expected
// output values for that cycle into a queue. The monitor drains the queue on
// every falling edge and compares each entry against the DUT.
// ----------------------------------------------------------------------------
module tb_router_sync_n;

   logic       clk;
   logic       resetn;
   logic       detect_add;
   logic [1:0] address;
   logic       write_enb_reg;
   logic [2:0] read_enb;
   logic [2:0] empty;
   logic [2:0] full;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic [2:0] vld_out;
   logic [2:0] soft_reset;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
   logic       addr_err;
`endif

   router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .detect_add   (detect_add),
      .address      (address),
      .write_enb_reg(write_enb_reg),
      .read_enb     (read_enb),
      .empty        (empty),
      .full         (full),
      .write_enb    (write_enb),
      .fifo_full    (fifo_full),
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      .addr_err     (addr_err),
`endif
      .vld_out      (vld_out),
      .soft_reset   (soft_reset)
   );

   // field: 0 write_enb, 1 fifo_full, 2 soft_reset, 3 vld_out, 4 addr_err
   typedef struct {
      string       name;
      int unsigned field;
      logic [7:0]  exp;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic expect_val(input string n, input int unsigned f, input logic [7:0] v);
      exp_t e;
      e.name  = n;
      e.field = f;
      e.exp   = v;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.field)
               0:       act = 8'(write_enb);
               1:       act = 8'(fifo_full);
               2:       act = 8'(soft_reset);
               3:       act = 8'(vld_out);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
               4:       act = 8'(addr_err);
`endif
               default: act = 8'hxx;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %b expected %b at %0t", e.name, act, e.exp, $time);
            end
         end
      end
   end

   // Stimulus
   initial begin
      resetn        = 1'b0;
      detect_add    = 1'b0;
      address       = 2'd0;
      write_enb_reg = 1'b0;
      read_enb      = 3'b000;
      empty         = 3'b111;
      full          = 3'b000;

      // Reset state
      step();
      step();
      write_enb_reg = 1'b1;
      expect_val("rst_write_enb", 0, 8'b001);
      expect_val("rst_soft_reset", 2, 8'b000);
      expect_val("rst_vld_out", 3, 8'b000);
      expect_val("rst_fifo_full", 1, 8'b0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      expect_val("rst_addr_err", 4, 8'b0);
`endif
      step();
      resetn        = 1'b1;
      write_enb_reg = 1'b0;

      // One-hot steering for each valid channel
      for (int a = 0; a < 3; a++) begin
         step();
         detect_add = 1'b1;
         address    = 2'(a);
         expect_val("hdr_no_wr", 0, 8'b000);
         step();
         detect_add    = 1'b0;
         write_enb_reg = 1'b1;
         expect_val($sformatf("wr_ch%0d", a), 0, 8'(3'b001 << a));
         step();
         write_enb_reg = 1'b0;
      end

      // fifo_full follows the latched channel (addr_reg = 2)
      full = 3'b100;
      expect_val("full_ch2_set", 1, 8'b1);
      step();
      full = 3'b011;
      expect_val("full_ch2_clr", 1, 8'b0);
      step();

      // Out-of-range address masks everything
      detect_add = 1'b1;
      address    = 2'd3;
      step();
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      full          = 3'b111;
      expect_val("addr3_write_enb", 0, 8'b000);
      expect_val("addr3_fifo_full", 1, 8'b0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      expect_val("addr3_addr_err", 4, 8'b1);
`endif
      step();
      write_enb_reg = 1'b0;
      full          = 3'b000;
      detect_add    = 1'b1;
      address       = 2'd0;
      step();
      detect_add = 1'b0;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      expect_val("addr0_addr_err_clr", 4, 8'b0);
`endif
      expect_val("addr0_write_idle", 0, 8'b000);
      step();

      // Header and write in the same cycle use the old address
      detect_add    = 1'b1;
      address       = 2'd1;
      write_enb_reg = 1'b1;
      expect_val("same_cycle_old", 0, 8'b001);
      step();
      detect_add = 1'b0;
      expect_val("same_cycle_new", 0, 8'b010);
      step();
      write_enb_reg = 1'b0;

      // Channel 1 unread for 60 edges: pulses after edge 30 and edge 60
      empty    = 3'b101;
      read_enb = 3'b000;
      expect_val("ch1_vld_out", 3, 8'b010);
      expect_val("ch1_pre", 2, 8'b000);
      for (int k = 1; k <= 60; k++) begin
         step();
         expect_val($sformatf("ch1_tmo_e%0d", k), 2, (k == 30 || k == 60) ? 8'b010 : 8'b000);
      end
      empty = 3'b111;
      step();
      expect_val("ch1_after", 2, 8'b000);

      // Channel 0 read at edge 29 restarts the count: no pulse in 58 edges
      empty = 3'b110;
      for (int k = 1; k <= 58; k++) begin
         read_enb = (k == 29) ? 3'b001 : 3'b000;
         step();
         expect_val($sformatf("ch0_read_e%0d", k), 2, 8'b000);
      end
      read_enb = 3'b000;
      empty    = 3'b111;
      step();
      expect_val("ch0_after", 2, 8'b000);

      // Channel 2 reset at count 20 discards the partial count
      empty = 3'b011;
      for (int k = 1; k <= 20; k++) begin
         step();
         expect_val($sformatf("ch2_pre_e%0d", k), 2, 8'b000);
      end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      expect_val("ch2_in_reset", 2, 8'b000);
      for (int k = 1; k <= 30; k++) begin
         step();
         expect_val($sformatf("ch2_post_e%0d", k), 2, (k == 30) ? 8'b100 : 8'b000);
      end
      empty = 3'b111;
      step();
      expect_val("ch2_after", 2, 8'b000);

      // Channels 0 and 1 time out together
      empty = 3'b100;
      for (int k = 1; k <= 31; k++) begin
         step();
         expect_val($sformatf("dual_e%0d", k), 2, (k == 30) ? 8'b011 : 8'b000);
      end
      empty = 3'b111;
      step();

      // Let the monitor drain; a leftover entry counts as a failure
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
